// File: rtl/riscv_pkg.sv
// Shared definitions for the branch/PC datapath: branch funct3 codes,
// PC-unit FSM encoding and default reset/trap addresses.
package riscv_pkg;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0100;

    // Instruction fetch addresses must be word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition resolver: maps funct3 and the flags of A-B onto a taken bit.
import riscv_pkg::*;

module branch_cond (
    input  logic [2:0] BranchType,
    input  logic       Zero,
    input  logic       Sign_Flag,
    output logic       cond
);

    // BLT/BGE read the raw sign of A-B; signed overflow is deliberately not corrected.
    always_comb begin
        cond = 1'b0;
        case (BranchType)
            F3_BEQ:  cond = Zero;
            F3_BNE:  cond = !Zero;
            F3_BLT:  cond = Sign_Flag;
            F3_BGE:  cond = !Sign_Flag;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Architectural PC register with branch/jump resolution and misaligned-target trap.
// Optional EPC output and register when BRANCH_PC_EPC_EN is defined.
import riscv_pkg::*;

module branch_pc_unit #(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Zero,
    input  logic        Sign_Flag,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ImmExt,
    input  logic        Branch,
    input  logic [2:0]  BranchType,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic        Stall,
    input  logic        TrapAck,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Taken,
    output logic        Trap
`ifdef BRANCH_PC_EPC_EN
    ,
    output logic [31:0] EPC
`endif
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target;
    logic        cond;
    logic        redirect;
    logic        enter_trap;

    branch_cond u_branch_cond (
        .BranchType (BranchType),
        .Zero       (Zero),
        .Sign_Flag  (Sign_Flag),
        .cond       (cond)
    );

    assign PCPlus4  = pc_q + 32'd4;
    assign target   = (Jump && JumpReg) ? (ALUResult & ~32'd1) : (pc_q + ImmExt);
    assign redirect = Jump || (Branch && cond);
    assign Taken    = (state_q == RUN) && !Stall && redirect;
    assign PC       = pc_q;
    assign Trap     = (state_q == TRAP);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        enter_trap = 1'b0;
        case (state_q)
            RUN: begin
                if (Stall) begin
                    pc_d = pc_q;
                end else if (redirect) begin
                    if (is_misaligned(target)) begin
                        pc_d       = TRAP_VECTOR;
                        state_d    = TRAP;
                        enter_trap = 1'b1;
                    end else begin
                        pc_d = target;
                    end
                end else begin
                    pc_d = PCPlus4;
                end
            end
            TRAP: begin
                // The handler resumes sequentially from the vector.
                if (TrapAck) begin
                    pc_d    = PCPlus4;
                    state_d = RUN;
                end
            end
            default: begin
                pc_d    = RESET_PC;
                state_d = RUN;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef BRANCH_PC_EPC_EN
    logic [31:0] epc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_q <= 32'd0;
        end else if (enter_trap) begin
            epc_q <= pc_q;
        end
    end

    assign EPC = epc_q;
`else
    logic unused_enter_trap;
    assign unused_enter_trap = enter_trap;
`endif

endmodule
